// File: rtl/instr_fetch_stage_if.sv
// Bundles the instruction-memory port, the redirect input and the decode-side
// output register of the fetch stage.
interface instr_fetch_if #(
  parameter int CNT_W = 32
);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic [31:0]      instr_pc;
  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr, op, funct, instr_pc, pc_plus4, instr_cnt
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr, op, funct, instr_pc, pc_plus4, instr_cnt
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time and
// holds the fetched word for decode behind a valid/ready handshake.
//
// state | meaning
// IDLE  | first cycle after reset, no request
// FETCH | request outstanding at pc_q
// FULL  | output register holds an instruction awaiting decode
// FLUSH | stale request outstanding; its data is dropped, then fetch at redir_q
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      redir_q, redir_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      ipc_q, ipc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req;
  logic [31:0]      target;

  assign target = bus.redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      redir_q <= 32'h0;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (bus.redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
        end
      end
      FETCH: begin
        req = 1'b1;
        if (bus.redirect) begin
          // A same-cycle ack lets us drop the word and retarget immediately.
          if (bus.imem_ack) begin
            pc_d = target;
          end else begin
            redir_d = target;
            state_d = FLUSH;
          end
        end else if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.redirect) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = FETCH;
        end else if (bus.instr_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = FETCH;
        end
      end
      FLUSH: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          pc_d    = bus.redirect ? target : redir_q;
          state_d = FETCH;
        end else if (bus.redirect) begin
          redir_d = target;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.op          = instr_q[31:26];
  assign bus.funct       = instr_q[5:0];
  assign bus.instr_pc    = ipc_q;
  assign bus.pc_plus4    = ipc_q + 32'd4;
  assign bus.instr_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: a memory responder, directed and random
// stimulus, and a scoreboard of the PCs decode is expected to accept.
module tb_instr_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_w = 1'b1;

  always #5 clk = ~clk;

  instr_fetch_if #(.CNT_W(32)) bus ();
  instr_fetch_if #(.CNT_W(32)) bus_w ();

  instr_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) dut_w (
    .clk(clk), .rst(rst_w), .bus(bus_w));

  int          checks = 0;
  int          failures = 0;
  int          acc_count = 0;
  logic [31:0] exp_q[$];
  int          wait_cfg = 0;
  bit          rand_wait = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h0109_5020;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected stream after a reset or redirect: consecutive words from the target.
  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  task automatic step();
    @(negedge clk);
    #2;
    bus.redirect = 1'b0;
  endtask

  task automatic wait_cond(input int which, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      case (which)
        0: ok = bus.imem_req;
        1: ok = bus.instr_valid;
        2: ok = bus.imem_ack;
        3: ok = bus_w.instr_valid;
        default: ok = bus_w.imem_req;
      endcase
      if (ok) break;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s actual=no_event required=event_within_60_cycles", name);
    end
  endtask

  // Memory responders: drive ack/rdata 1 time unit after the falling edge.
  initial begin
    bit busy = 1'b0;
    int cur_wait = 0;
    int wcnt = 0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus_w.imem_ack = 1'b0;
    bus_w.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (rst || !bus.imem_req) begin
        busy = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = 0;
          cur_wait = rand_wait ? int'($urandom_range(0, 3)) : wait_cfg;
        end
        if (wcnt >= cur_wait) begin
          bus.imem_ack = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
          busy = 1'b0;
        end else begin
          bus.imem_ack = 1'b0;
          bus.imem_rdata = $urandom;
          wcnt++;
        end
      end
      bus_w.imem_ack = bus_w.imem_req && !rst_w;
      bus_w.imem_rdata = mem_word(bus_w.imem_addr);
    end
  end

  // Monitor/scoreboard: samples just before each rising edge.
  initial begin
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] e;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("req_held", 32'(bus.imem_req), 32'h1);
          check("addr_stable", bus.imem_addr, pend_addr);
        end
        if (bus.instr_valid) check("req_low_when_full", 32'(bus.imem_req), 32'h0);
        if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual=accept required=no_accept pc=%h", bus.instr_pc);
          end else begin
            e = exp_q.pop_front();
            w = mem_word(e);
            check("sb_pc", bus.instr_pc, e);
            check("sb_instr", bus.instr, w);
            check("sb_op", 32'(bus.op), 32'(w[31:26]));
            check("sb_funct", 32'(bus.funct), 32'(w[5:0]));
            check("sb_pc_plus4", bus.pc_plus4, e + 32'd4);
            check("sb_cnt", bus.instr_cnt, 32'(acc_count));
            acc_count++;
          end
        end
        pend = bus.imem_req && !bus.imem_ack;
        pend_addr = bus.imem_addr;
      end
    end
  end

  initial begin
    bit          ok;
    logic [31:0] rec_instr, rec_pc, rec_cnt, t;
    int          since;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b1;
    bus_w.redirect = 1'b0;
    bus_w.redirect_pc = 32'h0;
    bus_w.instr_ready = 1'b1;
    refill(32'h0);

    // Reset held for three cycles, then streaming at zero wait
    for (int i = 0; i < 3; i++) step();
    check("rst_req", 32'(bus.imem_req), 32'h0);
    check("rst_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_cnt", bus.instr_cnt, 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    rst = 1'b0;
    wait_cond(0, "first_req", ok);
    check("first_addr", bus.imem_addr, 32'h0);
    step();
    check("s_op0", 32'(bus.op), 32'(6'b001000));
    check("s_pc0", bus.instr_pc, 32'h0);
    step();
    step();
    check("s_op1", 32'(bus.op), 32'h0);
    check("s_funct1", 32'(bus.funct), 32'h20);
    check("s_pc1", bus.instr_pc, 32'h4);
    step();
    check("s_cnt2", bus.instr_cnt, 32'h2);

    // Backpressure
    bus.instr_ready = 1'b0;
    wait_cond(1, "bp_valid", ok);
    rec_instr = bus.instr;
    rec_pc = bus.instr_pc;
    rec_cnt = bus.instr_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_instr", bus.instr, rec_instr);
      check("bp_pc", bus.instr_pc, rec_pc);
      check("bp_req", 32'(bus.imem_req), 32'h0);
      check("bp_cnt", bus.instr_cnt, rec_cnt);
      check("bp_valid", 32'(bus.instr_valid), 32'h1);
    end
    bus.instr_ready = 1'b1;
    wait_cond(0, "bp_next_req", ok);
    check("bp_next_addr", bus.imem_addr, rec_pc + 32'd4);

    // Redirect while a slow fetch is pending
    bus.instr_ready = 1'b0;
    wait_cond(1, "rd_valid", ok);
    wait_cfg = 3;
    bus.instr_ready = 1'b1;
    wait_cond(0, "rd_req", ok);
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    refill(32'h40);
    wait_cond(2, "rd_ack", ok);
    wait_cfg = 0;
    wait_cond(0, "rd_next_req", ok);
    check("rd_addr", bus.imem_addr, 32'h40);

    // Redirect with a same-cycle ack, unaligned target
    bus.instr_ready = 1'b0;
    wait_cond(1, "ra_valid", ok);
    bus.instr_ready = 1'b1;
    wait_cond(0, "ra_req", ok);
    check("ra_ack", 32'(bus.imem_ack), 32'h1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h103;
    refill(32'h100);
    step();
    check("ra_req_after", 32'(bus.imem_req), 32'h1);
    check("ra_addr", bus.imem_addr, 32'h100);
    check("ra_valid_after", 32'(bus.instr_valid), 32'h0);

    // Redirect together with ready while FULL
    bus.instr_ready = 1'b0;
    wait_cond(1, "rr_valid", ok);
    rec_cnt = bus.instr_cnt;
    bus.instr_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    refill(32'h200);
    step();
    check("rr_cnt", bus.instr_cnt, rec_cnt);
    check("rr_valid", 32'(bus.instr_valid), 32'h0);
    check("rr_addr", bus.imem_addr, 32'h200);

    // Random waits, ready and redirects
    rand_wait = 1'b1;
    since = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0 || since >= 50) begin
        t = $urandom;
        if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
        bus.redirect = 1'b1;
        bus.redirect_pc = t;
        refill(t & 32'hFFFF_FFFC);
        since = 0;
      end else begin
        since++;
      end
    end
    rand_wait = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Reset in the middle of a request, redirect in the IDLE cycle
    wait_cfg = 3;
    wait_cond(0, "mr_req", ok);
    step();
    rst = 1'b1;
    acc_count = 0;
    refill(32'h0);
    step();
    check("mr_req_dropped", 32'(bus.imem_req), 32'h0);
    check("mr_cnt", bus.instr_cnt, 32'h0);
    step();
    wait_cfg = 0;
    rst = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h82;
    refill(32'h80);
    wait_cond(0, "mr_next_req", ok);
    check("mr_addr", bus.imem_addr, 32'h80);
    for (int i = 0; i < 10; i++) step();

    // PC wrap on an instance reset near the top of the address space
    rst_w = 1'b0;
    wait_cond(3, "wr_valid", ok);
    check("wr_pc", bus_w.instr_pc, 32'hFFFF_FFFC);
    check("wr_pc_plus4", bus_w.pc_plus4, 32'h0);
    check("wr_instr", bus_w.instr, mem_word(32'hFFFF_FFFC));
    wait_cond(4, "wr_next_req", ok);
    check("wr_next_addr", bus_w.imem_addr, 32'h0);
    wait_cond(3, "wr_valid2", ok);
    check("wr_pc2", bus_w.instr_pc, 32'h0);
    check("wr_cnt", bus_w.instr_cnt, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
